uart_tx: RTL and testbench

//   Serial UART transmitter, companion to the existing 8N1 receiver: 1 start bit (0), 8 data bits LSB first,
//   1 stop bit (1), no parity. Bytes enter through a valid/ready port into a small FIFO and are serialized

---
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a small byte FIFO.
// Frames are 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit
// lasting CLKS_PER_BIT clocks. Queued bytes go out back-to-back with no idle gap.
// The pin register is loaded from the current state, so the line follows the
// FSM by one clock: a byte popped at edge k drives the start bit from edge k+1.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          pin,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_q;
  logic          push, pop;

  // FSM / datapath state
  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          pin_q, pin_d;
  logic          bit_done;

  assign ready      = (count_q != FULL);
  assign push       = valid && ready;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE);
  assign pin        = pin_q;
  assign bit_done   = (cyc_q == LAST_CYC);

  // Byte storage: written on every accepted push.
  // NOTE: the data array has no reset; only the pointers and count need one, so
  // the storage maps onto plain RAM/flops without reset routing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW + 1)'(1);
        2'b01:   count_q <= count_q - (PW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state, bit timing, shift register and registered serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
    end
  end

  // Next-state, line level and FIFO pop decision.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pin_d   = 1'b1;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          cyc_d   = '0;
          state_d = START;
        end
      end
      START: begin
        pin_d = 1'b0;
        if (bit_done) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        pin_d = shift_q[0];
        if (bit_done) begin
          cyc_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        pin_d = 1'b1;
        if (bit_done) begin
          cyc_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives two transmitters (1 and 3 clocks per bit) from per-instance
// producer queues and compares every cycle against a frame-timeline model.
// The model schedules each popped byte as a 10-bit waveform in expected-value
// arrays; FIFO occupancy is just (bytes accepted - bytes popped).
module tb_uart_tx;

  localparam int D    = 4;
  localparam int CPB0 = 1;
  localparam int CPB1 = 3;
  localparam int MAXC = 16384;
  localparam int QN   = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       v    [2];
  logic [7:0] d    [2];
  logic       rdy  [2];
  logic       pin  [2];
  logic       busy [2];
  logic [2:0] cnt  [2];

  uart_tx #(.CLKS_PER_BIT(CPB0), .FIFO_DEPTH(D)) u_tx0 (
    .clk(clk), .rst(rst), .data(d[0]), .valid(v[0]), .ready(rdy[0]),
    .pin(pin[0]), .busy(busy[0]), .fifo_count(cnt[0]));

  uart_tx #(.CLKS_PER_BIT(CPB1), .FIFO_DEPTH(D)) u_tx1 (
    .clk(clk), .rst(rst), .data(d[1]), .valid(v[1]), .ready(rdy[1]),
    .pin(pin[1]), .busy(busy[1]), .fifo_count(cnt[1]));

  always #5 clk = ~clk;

  // Expected line and busy after each edge index
  bit         exp_pin  [2][MAXC];
  bit         exp_busy [2][MAXC];
  // Model FIFO contents and producer queue, as ring buffers
  logic [7:0] mbuf [2][QN];
  int         mhead [2], mtail [2];
  logic [7:0] sbuf [2][QN];
  int         shead [2], stail [2];
  int         free_edge [2];
  int         edge_n;
  int         rate;
  int         n_cmp, n_bad;

  function automatic int cpb(input int i);
    return (i == 0) ? CPB0 : CPB1;
  endfunction

  task automatic check(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cpb=%0d edge=%0d: observed %0h expected %0h",
             tag, cpb(inst), edge_n, obs, exp);
    end
  endtask

  // One clock: decide model push/pop from pre-edge values, apply at the edge,
  // compare at the falling edge, then drive the next inputs.
  task automatic step();
    bit         push [2];
    bit         pop  [2];
    int         occ;
    int         e;
    logic [7:0] b;
    logic [9:0] fr;
    for (int i = 0; i < 2; i++) begin
      occ     = mtail[i] - mhead[i];
      push[i] = v[i] && (occ != D);
      pop[i]  = (occ != 0) && (edge_n >= free_edge[i]);
    end
    @(posedge clk);
    e = edge_n;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mhead[i]     = mtail[i];
        free_edge[i] = 0;
        for (int t = e; t < e + 64 && t < MAXC; t++) begin
          exp_pin[i][t]  = 1'b1;
          exp_busy[i][t] = 1'b0;
        end
      end else begin
        if (pop[i]) begin
          b  = mbuf[i][mhead[i] % QN];
          mhead[i]++;
          fr = {1'b1, b, 1'b0};
          for (int t = 0; t < 10 * cpb(i); t++) begin
            exp_busy[i][e + t]    = 1'b1;
            exp_pin[i][e + 1 + t] = fr[t / cpb(i)];
          end
          free_edge[i] = e + 10 * cpb(i);
        end
        if (push[i]) begin
          mbuf[i][mtail[i] % QN] = d[i];
          mtail[i]++;
          shead[i]++;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      occ = mtail[i] - mhead[i];
      check("pin",        i, 32'(pin[i]),  32'(exp_pin[i][e]));
      check("busy",       i, 32'(busy[i]), 32'(exp_busy[i][e]));
      check("fifo_count", i, 32'(cnt[i]),  occ);
      check("ready",      i, 32'(rdy[i]),  32'(occ != D));
    end
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        v[i] = 1'b0;
      end else if (v[i] && !push[i]) begin
        v[i] = 1'b1;  // hold an offered byte until it is taken
      end else if (stail[i] != shead[i] && $urandom_range(0, 99) < rate) begin
        v[i] = 1'b1;
        d[i] = sbuf[i][shead[i] % QN];
      end else begin
        v[i] = 1'b0;
        d[i] = 8'($urandom);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      sbuf[i][stail[i] % QN] = b;
      stail[i]++;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      shead[i] = stail[i];
      v[i]     = 1'b0;
    end
    run(n);
    rst = 1'b0;
  endtask

  function automatic bit model_idle();
    for (int i = 0; i < 2; i++)
      if (stail[i] != shead[i] || mtail[i] != mhead[i] || edge_n <= free_edge[i])
        return 1'b0;
    return 1'b1;
  endfunction

  // Run until every queued byte has been sent, within a cycle budget.
  task automatic drain(input int limit);
    int k = 0;
    while (!model_idle() && k < limit) begin
      step();
      k++;
    end
    n_cmp++;
    assert (k < limit) else begin
      n_bad++;
      $error("FAIL drain_timeout edge=%0d: observed %0d cycles expected below %0d",
             edge_n, k, limit);
    end
    run(3);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    edge_n = 0;
    rate   = 100;
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; mtail[i] = 0; shead[i] = 0; stail[i] = 0; free_edge[i] = 0;
      v[i] = 1'b0; d[i] = 8'h00;
      for (int t = 0; t < MAXC; t++) begin
        exp_pin[i][t]  = 1'b1;
        exp_busy[i][t] = 1'b0;
      end
    end
    rst = 1'b1;

    // Reset state
    do_reset(3);
    run(2);

    // Single frame 0xA5, then a single 0x01 frame
    send(8'hA5);
    drain(200);
    send(8'h01);
    drain(200);

    // Six bytes with valid held: FIFO fills, ready drops, frames run back-to-back
    for (int k = 0; k < 6; k++) send(8'(8'h10 + k));
    drain(400);

    // Bytes that a loopback receiver must see in order
    send(8'h3C);
    send(8'hFF);
    send(8'h00);
    drain(300);

    // Reset during the DATA phase with two bytes still queued
    send(8'hC3);
    send(8'h5A);
    send(8'h96);
    run(8);
    do_reset(1);
    run(40);

    // Keep the FIFO full so pushes coincide with pops at frame ends
    for (int k = 0; k < 8; k++) send(8'($urandom));
    drain(600);

    // Random bytes with random valid gaps
    rate = 40;
    for (int k = 0; k < 60; k++) send(8'($urandom));
    drain(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
